// File: rtl/skewed_addr_gen_pkg.sv
// Shared constants and state encoding for the skewed (systolic) address generator.
// The default lane address width matches the downstream address selector bus.
package skewed_addr_gen_pkg;

  localparam int ADDR_W             = 14;
  localparam int DEFAULT_ARRAY_SIZE = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/skewed_addr_gen_if.sv
// Bundles the sweep request and the skewed lane outputs of skewed_addr_gen.
// The master side drives a sweep; the slave side is the generator itself.
interface skewed_addr_gen_if
  import skewed_addr_gen_pkg::*;
#(
  parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter int ADDR_W     = skewed_addr_gen_pkg::ADDR_W
) ();

  logic                         start;
  logic [ADDR_W-1:0]            base_addr;
  logic [ADDR_W-1:0]            row_stride;
  logic [ADDR_W-1:0]            num_steps;
  logic                         enable;
  logic [ADDR_W*ARRAY_SIZE-1:0] addr_out;
  logic [ARRAY_SIZE-1:0]        addr_valid;
  logic                         busy;
  logic                         done;

  modport master (
    output start, base_addr, row_stride, num_steps, enable,
    input  addr_out, addr_valid, busy, done
  );

  modport slave (
    input  start, base_addr, row_stride, num_steps, enable,
    output addr_out, addr_valid, busy, done
  );

endinterface

// File: rtl/skewed_addr_gen_addr_lane.sv
// One systolic lane: offset latched at sweep start, then a running address that
// is valid while the lane's skewed step (t - LANE) lies inside 0..num_steps-1.
module addr_lane
  import skewed_addr_gen_pkg::*;
#(
  parameter int LANE   = 0,
  parameter int ADDR_W = skewed_addr_gen_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_latch,
  input  logic              i_advance,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_base_in,
  input  logic [ADDR_W-1:0] i_stride_in,
  input  logic [ADDR_W-1:0] i_steps_in,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_steps,
  input  logic [ADDR_W:0]   i_t_next,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid
);

  localparam int T_W = ADDR_W + 1;

  logic [ADDR_W-1:0] r_offset;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic [T_W-1:0]    w_rel;
  logic              w_in_window;
  logic              w_first_at_latch;

  assign w_rel            = i_t_next - T_W'(LANE);
  assign w_in_window      = (i_t_next >= T_W'(LANE)) && (w_rel < {1'b0, i_steps});
  assign w_first_at_latch = (LANE == 0) && (i_steps_in != '0);

  // The window is contiguous, so after the first valid step the address just counts up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_offset <= '0;
      r_addr   <= '0;
      r_valid  <= 1'b0;
    end else if (i_latch) begin
      r_offset <= ADDR_W'(LANE) * i_stride_in;
      r_valid  <= w_first_at_latch;
      r_addr   <= w_first_at_latch ? i_base_in : '0;
    end else if (i_clear) begin
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else if (i_advance) begin
      r_valid <= w_in_window;
      if (!w_in_window)
        r_addr <= '0;
      else if (r_valid)
        r_addr <= r_addr + ADDR_W'(1);
      else
        r_addr <= i_base + r_offset;
    end
  end

  assign o_addr  = r_addr;
  assign o_valid = r_valid;

endmodule

// File: rtl/skewed_addr_gen.sv
// Generates skewed per-lane addresses for a systolic array: lane r issues
// base + r*stride + (t - r) for num_steps steps, starting r cycles after lane 0.
module skewed_addr_gen
  import skewed_addr_gen_pkg::*;
#(
  parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter int ADDR_W     = skewed_addr_gen_pkg::ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [ADDR_W-1:0]            row_stride,
  input  logic [ADDR_W-1:0]            num_steps,
  input  logic                         enable,
  output logic [ADDR_W*ARRAY_SIZE-1:0] addr_out,
  output logic [ARRAY_SIZE-1:0]        addr_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int T_W = ADDR_W + 1;

  state_t            r_state;
  logic [T_W-1:0]    r_t;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_steps;
  logic              r_busy;
  logic              r_done;

  logic [T_W-1:0]    w_last;
  logic [T_W-1:0]    w_t_next;
  logic              w_latch;
  logic              w_step;
  logic              w_advance;
  logic              w_finish;

  // Last step index is num_steps + ARRAY_SIZE - 2; the extra counter bit keeps it exact.
  assign w_last    = {1'b0, r_steps} + T_W'(ARRAY_SIZE - 2);
  assign w_t_next  = r_t + T_W'(1);
  assign w_latch   = (r_state == IDLE) && start;
  assign w_step    = (r_state == RUN) && enable;
  assign w_advance = w_step && (r_t != w_last);
  assign w_finish  = w_step && (r_t == w_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_base  <= '0;
      r_steps <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base  <= base_addr;
            r_steps <= num_steps;
            r_t     <= '0;
            r_busy  <= 1'b1;
            if (num_steps == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (enable) begin
            if (r_t == w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_t <= w_t_next;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_t     <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    addr_lane #(
      .LANE   (g),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .i_latch     (w_latch),
      .i_advance   (w_advance),
      .i_clear     (w_finish),
      .i_base_in   (base_addr),
      .i_stride_in (row_stride),
      .i_steps_in  (num_steps),
      .i_base      (r_base),
      .i_steps     (r_steps),
      .i_t_next    (w_t_next),
      .o_addr      (addr_out[ADDR_W*g +: ADDR_W]),
      .o_valid     (addr_valid[g])
    );
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule
